dead_time_inserter: RTL and testbench

//  Three-phase dead-time stage downstream of the SPWM comparators. Takes raw phase demands Va/Vb/Vc.

---
 rtl/dead_time_inserter_pkg.sv | 35 +++
 rtl/dead_time_phase.sv | 127 ++++++++++++
 rtl/dead_time_inserter.sv | 85 ++++++++
 tb/tb_dead_time_inserter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dead_time_inserter_pkg.sv
// -----------------------------------------------------------------------------
// dead_time_inserter_pkg
//   Shared types for the three-phase dead-time stage.
//   - phase_state_e : per-phase FSM state, fixed 3-bit encodings
//   - gate_pair_t   : high/low gate drive pair of one phase
//   - gates_of()    : decode of an FSM state into its gate pair
// -----------------------------------------------------------------------------
package dead_time_inserter_pkg;

  localparam int unsigned DT_CYCLES_DEF = 50;
  localparam int unsigned CNT_W_DEF     = 8;

  typedef enum logic [2:0] {
    S_SAFE    = 3'd0,
    S_DT_TO_H = 3'd1,
    S_H_ON    = 3'd2,
    S_DT_TO_L = 3'd3,
    S_L_ON    = 3'd4
  } phase_state_e;

  typedef struct packed {
    logic g_h;
    logic g_l;
  } gate_pair_t;

  // Only the two conduction states drive a gate, so both gates can never be
  // high together whatever state is decoded.
  function automatic gate_pair_t gates_of(input phase_state_e s);
    gate_pair_t g;
    g.g_h = (s == S_H_ON);
    g.g_l = (s == S_L_ON);
    return g;
  endfunction

endpackage

// File: rtl/dead_time_phase.sv
// -----------------------------------------------------------------------------
// dead_time_phase
//   One phase leg: registers the raw demand, runs the dead-time FSM with its
//   counter, and drives a registered complementary gate pair.
//   Ports:
//     clk    in  system clock, rising edge
//     reset  in  asynchronous, active-low reset
//     run    in  1 = allowed to conduct; 0 = go to SAFE on the next edge
//     demand in  raw phase demand, 1 = high side conducts
//     g_h    out high-side gate drive (registered)
//     g_l    out low-side gate drive (registered)
// -----------------------------------------------------------------------------
module dead_time_phase
  import dead_time_inserter_pkg::*;
#(
  parameter int unsigned DT_CYCLES = DT_CYCLES_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic demand,
  output logic g_h,
  output logic g_l
);

  if (DT_CYCLES == 0 || DT_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_dt
    $error("dead_time_phase: DT_CYCLES=%0d outside 1..2**CNT_W-1", DT_CYCLES);
  end

  localparam logic [CNT_W-1:0] DT_LOAD = CNT_W'(DT_CYCLES - 1);

  logic         d_q,         d_d;
  phase_state_e state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  // Set while the current dead time was entered from SAFE: there is then no
  // previous conduction state to fall back to, so a reversed demand restarts
  // a full dead time toward the other side instead of aborting.
  logic         from_safe_q, from_safe_d;
  gate_pair_t   gates_q,     gates_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    d_d         = demand;
    state_d     = state_q;
    cnt_d       = cnt_q;
    from_safe_d = from_safe_q;

    if (!run) begin
      // Turn-off needs no dead time: both gates simply drop.
      state_d = S_SAFE;
    end else begin
      unique case (state_q)
        S_SAFE: begin
          state_d     = d_q ? S_DT_TO_H : S_DT_TO_L;
          cnt_d       = DT_LOAD;
          from_safe_d = 1'b1;
        end
        S_H_ON: begin
          if (!d_q) begin
            state_d     = S_DT_TO_L;
            cnt_d       = DT_LOAD;
            from_safe_d = 1'b0;
          end
        end
        S_L_ON: begin
          if (d_q) begin
            state_d     = S_DT_TO_H;
            cnt_d       = DT_LOAD;
            from_safe_d = 1'b0;
          end
        end
        S_DT_TO_H: begin
          if (d_q) begin
            if (cnt_q == '0) state_d = S_H_ON;
            else             cnt_d   = cnt_q - CNT_W'(1);
          end else if (from_safe_q) begin
            state_d = S_DT_TO_L;
            cnt_d   = DT_LOAD;
          end else begin
            // Pulse narrower than the dead time: the high side was never on.
            state_d = S_L_ON;
          end
        end
        S_DT_TO_L: begin
          if (!d_q) begin
            if (cnt_q == '0) state_d = S_L_ON;
            else             cnt_d   = cnt_q - CNT_W'(1);
          end else if (from_safe_q) begin
            state_d = S_DT_TO_H;
            cnt_d   = DT_LOAD;
          end else begin
            state_d = S_H_ON;
          end
        end
        default: state_d = S_SAFE;
      endcase
    end

    // Gates are decoded from the next state so they switch on the same edge
    // as the FSM, then held in flops for glitch-free drive.
    gates_d = gates_of(state_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_q         <= 1'b0;
      state_q     <= S_SAFE;
      cnt_q       <= '0;
      from_safe_q <= 1'b0;
      gates_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      d_q         <= d_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      from_safe_q <= from_safe_d;
      gates_q     <= gates_d;
    end
  end

  assign g_h = gates_q.g_h;
  assign g_l = gates_q.g_l;

endmodule

// File: rtl/dead_time_inserter.sv
// -----------------------------------------------------------------------------
// dead_time_inserter
//   Three-phase dead-time stage between the SPWM comparators and the gate
//   drivers, with run enable and a latched fault shutdown.
//   Ports:
//     clk         in  system clock, rising edge
//     reset       in  asynchronous, active-low reset
//     en          in  run enable; low forces all gates off
//     fault_n     in  active-low fault request, synchronous to clk
//     fault_clr   in  clears the latched fault (ignored while fault_n=0)
//     Va, Vb, Vc  in  raw phase demands, 1 = high side conducts
//     ga_h..gc_l  out complementary gate drives per phase
//     fault_flag  out latched fault indicator
// -----------------------------------------------------------------------------
module dead_time_inserter
  import dead_time_inserter_pkg::*;
#(
  parameter int unsigned DT_CYCLES = DT_CYCLES_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic fault_n,
  input  logic fault_clr,
  input  logic Va,
  input  logic Vb,
  input  logic Vc,
  output logic ga_h,
  output logic ga_l,
  output logic gb_h,
  output logic gb_l,
  output logic gc_h,
  output logic gc_l,
  output logic fault_flag
);

  logic fault_flag_q, fault_flag_d;
  logic run;

  // An active fault request always wins over a clear in the same cycle.
  always_comb begin
    fault_flag_d = fault_flag_q;
    if (!fault_n)       fault_flag_d = 1'b1;
    else if (fault_clr) fault_flag_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fault_flag_q <= 1'b0;
    else        fault_flag_q <= fault_flag_d;
  end

  // fault_n is included directly so the FSMs go to SAFE on the same edge
  // that latches the fault, not one cycle later.
  assign run        = en & ~fault_flag_q & fault_n;
  assign fault_flag = fault_flag_q;

  dead_time_phase #(.DT_CYCLES(DT_CYCLES), .CNT_W(CNT_W)) u_phase_a (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .demand (Va),
    .g_h    (ga_h),
    .g_l    (ga_l)
  );

  dead_time_phase #(.DT_CYCLES(DT_CYCLES), .CNT_W(CNT_W)) u_phase_b (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .demand (Vb),
    .g_h    (gb_h),
    .g_l    (gb_l)
  );

  dead_time_phase #(.DT_CYCLES(DT_CYCLES), .CNT_W(CNT_W)) u_phase_c (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .demand (Vc),
    .g_h    (gc_h),
    .g_l    (gc_l)
  );

endmodule

// File: tb/tb_dead_time_inserter.sv
// -----------------------------------------------------------------------------
// tb_dead_time_inserter
//   Directed scoreboard checks on a DT_CYCLES=4 instance, plus continuous
//   overlap / minimum-dead-time monitoring of DT_CYCLES = 4, 1 and 50
//   instances that share the same stimulus, followed by a random run.
//   Observed vector layout: {fault_flag, ga_h, ga_l, gb_h, gb_l, gc_h, gc_l}.
// -----------------------------------------------------------------------------
module tb_dead_time_inserter;

  logic clk = 1'b0;
  logic rst_n, en, fault_n, fault_clr, va, vb, vc;
  logic [6:0] o4, o1, o50;

  always #5 clk = ~clk;

  dead_time_inserter #(.DT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .reset(rst_n), .en(en), .fault_n(fault_n), .fault_clr(fault_clr),
    .Va(va), .Vb(vb), .Vc(vc),
    .ga_h(o4[5]), .ga_l(o4[4]), .gb_h(o4[3]), .gb_l(o4[2]),
    .gc_h(o4[1]), .gc_l(o4[0]), .fault_flag(o4[6])
  );

  dead_time_inserter #(.DT_CYCLES(1), .CNT_W(8)) dut_dt1 (
    .clk(clk), .reset(rst_n), .en(en), .fault_n(fault_n), .fault_clr(fault_clr),
    .Va(va), .Vb(vb), .Vc(vc),
    .ga_h(o1[5]), .ga_l(o1[4]), .gb_h(o1[3]), .gb_l(o1[2]),
    .gc_h(o1[1]), .gc_l(o1[0]), .fault_flag(o1[6])
  );

  dead_time_inserter #(.DT_CYCLES(50), .CNT_W(8)) dut_dt50 (
    .clk(clk), .reset(rst_n), .en(en), .fault_n(fault_n), .fault_clr(fault_clr),
    .Va(va), .Vb(vb), .Vc(vc),
    .ga_h(o50[5]), .ga_l(o50[4]), .gb_h(o50[3]), .gb_l(o50[2]),
    .gc_h(o50[1]), .gc_l(o50[0]), .fault_flag(o50[6])
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle index: number of rising edges since reset was released.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    int         cyc;
    logic [6:0] mask;
    logic [6:0] val;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [6:0] ALL = 7'h7f;
  localparam logic [6:0] MA  = 7'b1110000;

  task automatic expect_range(input int c0, input int c1, input logic [6:0] mask,
                              input logic [6:0] val, input string tag);
    for (int c = c0; c <= c1; c++) exp_q.push_back('{c, mask, val, tag});
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check(e.tag, 32'(o4 & e.mask), 32'(e.val & e.mask));
    end
  end

  // ---------------------------------------------------------------- monitors
  int   dt_of     [3] = '{4, 1, 50};
  int   zero_run  [3][3];
  int   last_side [3][3];   // 0 none, 1 high, 2 low
  logic prev_h    [3][3];
  logic prev_l    [3][3];

  always @(negedge clk) begin
    logic [6:0] o [3];
    logic h, l;
    o[0] = o4; o[1] = o1; o[2] = o50;
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 3; p++) begin
        h = o[i][5 - 2 * p];
        l = o[i][4 - 2 * p];
        if (!rst_n) begin
          zero_run[i][p]  = 0;
          last_side[i][p] = 0;
          prev_h[i][p]    = 1'b0;
          prev_l[i][p]    = 1'b0;
          check("reset_gates_off", 32'({h, l}), 32'd0);
        end else begin
          check("overlap", 32'(h & l), 32'd0);
          if (h && !prev_h[i][p]) begin
            if (last_side[i][p] != 1)
              check("dead_time_to_h", 32'(zero_run[i][p] >= dt_of[i]), 32'd1);
            last_side[i][p] = 1;
          end
          if (l && !prev_l[i][p]) begin
            if (last_side[i][p] != 2)
              check("dead_time_to_l", 32'(zero_run[i][p] >= dt_of[i]), 32'd1);
            last_side[i][p] = 2;
          end
          if (!h && !l) zero_run[i][p]++;
          else          zero_run[i][p] = 0;
          prev_h[i][p] = h;
          prev_l[i][p] = l;
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic wait_cycle(input int c);
    int guard = 0;
    while (cyc < c && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != c) check("wait_timeout", 32'(cyc), 32'(c));
  endtask

  int rates [5] = '{500, 100, 30, 8, 3};

  initial begin
    rst_n = 1'b0; en = 1'b1; fault_n = 1'b1; fault_clr = 1'b0;
    va = 1'b1; vb = 1'b0; vc = 1'b0;

    // Reset state and start-up with Va=1 held.
    #20;
    check("reset_state_dt4",  32'(o4),  32'd0);
    check("reset_state_dt1",  32'(o1),  32'd0);
    check("reset_state_dt50", 32'(o50), 32'd0);
    expect_range(1, 4, ALL, 7'b0000000, "startup_off");
    expect_range(5, 5, ALL, 7'b0000101, "startup_low_on");
    expect_range(6, 6, ALL, 7'b0100101, "startup_high_on");
    #2 rst_n = 1'b1;

    // High -> low transition.
    wait_cycle(8);  va = 1'b0;
    expect_range(9, 9,   MA, 7'b0100000, "fall_hold");
    expect_range(10, 13, MA, 7'b0000000, "fall_dead");
    expect_range(14, 14, MA, 7'b0010000, "fall_low_on");

    // Low -> high transition.
    wait_cycle(16); va = 1'b1;
    expect_range(17, 17, MA, 7'b0010000, "rise_hold");
    expect_range(18, 21, MA, 7'b0000000, "rise_dead");
    expect_range(22, 22, MA, 7'b0100000, "rise_high_on");

    // 3-cycle low glitch: dead time aborted back to high side.
    wait_cycle(24); va = 1'b0;
    expect_range(25, 25, MA, 7'b0100000, "glitch3_hold");
    expect_range(26, 28, MA, 7'b0000000, "glitch3_dead");
    expect_range(29, 33, MA, 7'b0100000, "glitch3_back_high");
    wait_cycle(27); va = 1'b1;

    // Pulse exactly DT_CYCLES long: still no low-side conduction.
    wait_cycle(34); va = 1'b0;
    expect_range(35, 35, MA, 7'b0100000, "glitch4_hold");
    expect_range(36, 39, MA, 7'b0000000, "glitch4_dead");
    expect_range(40, 41, MA, 7'b0100000, "glitch4_back_high");
    wait_cycle(38); va = 1'b1;

    // Pulse DT_CYCLES+1 long: low side conducts, then full dead time back.
    wait_cycle(42); va = 1'b0;
    expect_range(43, 43, MA,  7'b0100000, "pulse5_hold");
    expect_range(44, 47, MA,  7'b0000000, "pulse5_dead");
    expect_range(48, 48, MA,  7'b0010000, "pulse5_low_on");
    expect_range(49, 52, MA,  7'b0000000, "pulse5_dead_back");
    expect_range(53, 53, ALL, 7'b0100101, "pulse5_high_on");
    wait_cycle(47); va = 1'b1;

    // One-cycle fault while running, then clear.
    wait_cycle(56); fault_n = 1'b0;
    expect_range(56, 56, ALL, 7'b0100101, "pre_fault");
    expect_range(57, 61, ALL, 7'b1000000, "fault_hold");
    wait_cycle(57); fault_n = 1'b1;
    wait_cycle(61); fault_clr = 1'b1;
    expect_range(62, 66, ALL, 7'b0000000, "clr_dead");
    expect_range(67, 67, ALL, 7'b0100101, "clr_resume");
    wait_cycle(62); fault_clr = 1'b0;

    // Fault and clear together: fault wins.
    wait_cycle(70); fault_n = 1'b0; fault_clr = 1'b1;
    expect_range(71, 75, ALL, 7'b1000000, "fault_beats_clr");
    wait_cycle(72); fault_n = 1'b1; fault_clr = 1'b0;
    wait_cycle(75); fault_clr = 1'b1;
    expect_range(76, 80, ALL, 7'b0000000, "clr2_dead");
    expect_range(81, 81, ALL, 7'b0100101, "clr2_resume");
    wait_cycle(76); fault_clr = 1'b0;

    // en dropped in the middle of a dead time.
    wait_cycle(83); va = 1'b0;
    expect_range(84, 84, ALL, 7'b0100101, "en_pre_hold");
    expect_range(85, 86, ALL, 7'b0000101, "en_pre_dead");
    wait_cycle(86); en = 1'b0;
    expect_range(87, 92, ALL, 7'b0000000, "en_off_safe");
    wait_cycle(88); en = 1'b1;
    expect_range(93, 93, ALL, 7'b0010101, "en_resume");

    // Asynchronous reset in the middle of a dead time.
    wait_cycle(95); va = 1'b1;
    expect_range(96, 96, ALL, 7'b0010101, "async_pre_hold");
    expect_range(97, 98, ALL, 7'b0000101, "async_pre_dead");
    wait_cycle(98);
    #6 rst_n = 1'b0;
    #1;
    check("async_reset_dt4",  32'(o4),  32'd0);
    check("async_reset_dt50", 32'(o50), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Random run across all three instances.
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 30000; i++) begin
      int r;
      @(posedge clk);
      #1;
      r = rates[(i / 2000) % 5];
      if ($urandom_range(0, 999) < r) va = ~va;
      if ($urandom_range(0, 999) < r) vb = ~vb;
      if ($urandom_range(0, 999) < r) vc = ~vc;
      en        = ($urandom_range(0, 999) >= 2);
      fault_n   = ($urandom_range(0, 2999) != 0);
      fault_clr = ($urandom_range(0, 99) == 0);
    end

    check("scoreboard_unserved", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
